// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the limit-controlled FIFO family.
// cap_of widens before adding so limit = DEPTH-1 yields DEPTH without truncation.
package fifo_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;
  localparam int unsigned DEFAULT_ADDR_W = 2;

  function automatic int unsigned cap_of(input int unsigned limit);
    return limit + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port register array: synchronous write, asynchronous read.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [DATA_W-1:0] read_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[write_addr] <= write_data;
    end
  end

  assign read_data = mem[read_addr];

endmodule

// File: rtl/limit_fifo.sv
// Single-clock FIFO with run-time capacity limit, occupancy count and sticky error flags.
// Full/empty derive only from count, so pointer wrap never needs disambiguation.
module limit_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter bit          FWFT   = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_en,
  output logic [DATA_W-1:0] data_out,
  input  logic [ADDR_W-1:0] limit,
  input  logic              clear_errors,
  output logic              is_full,
  output logic              is_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   cap;
  logic              wr_ok;
  logic              rd_ok;
  logic [DATA_W-1:0] ram_data;

  // Live limit feeds full immediately; acceptance uses pre-edge state.
  always_comb begin
    cap      = (ADDR_W+1)'(cap_of(32'(limit)));
    is_full  = (count >= cap);
    is_empty = (count == '0);
    wr_ok    = write_en & ~is_full;
    rd_ok    = read_en & ~is_empty;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_ok) rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A new error in the same cycle as clear_errors keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_en & is_full)  overflow <= 1'b1;
      else if (clear_errors)   overflow <= 1'b0;
      if (read_en & is_empty)  underflow <= 1'b1;
      else if (clear_errors)   underflow <= 1'b0;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk        (clk),
    .write_en   (wr_ok),
    .write_addr (wr_ptr),
    .write_data (data_in),
    .read_addr  (rd_ptr),
    .read_data  (ram_data)
  );

  if (FWFT) begin : g_fwft
    assign data_out = ram_data;
  end else begin : g_reg
    logic [DATA_W-1:0] data_q;
    always_ff @(posedge clk) begin
      if (reset)      data_q <= '0;
      else if (rd_ok) data_q <= ram_data;
    end
    assign data_out = data_q;
  end

endmodule

// File: tb/tb_limit_fifo.sv
// Bench for limit_fifo: registered-read and FWFT instances share stimulus and a queue model.
module tb_limit_fifo;

  logic       clk = 1'b0;
  logic       reset, write_en, read_en, clear_errors;
  logic [7:0] data_in;
  logic [1:0] limit;

  logic [7:0] d0, d1;
  logic       full0, full1, empty0, empty1, ovf0, ovf1, udf0, udf1;
  logic [2:0] cnt0, cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q[$];
  logic [7:0] m_dout;
  bit         m_ovf, m_udf;
  bit         model_valid = 1'b0;

  always #5 clk = ~clk;

  limit_fifo #(.DATA_W(8), .ADDR_W(2), .FWFT(1'b0)) dut_reg (
    .clk(clk), .reset(reset), .write_en(write_en), .data_in(data_in), .read_en(read_en),
    .data_out(d0), .limit(limit), .clear_errors(clear_errors), .is_full(full0),
    .is_empty(empty0), .count(cnt0), .overflow(ovf0), .underflow(udf0));

  limit_fifo #(.DATA_W(8), .ADDR_W(2), .FWFT(1'b1)) dut_fwft (
    .clk(clk), .reset(reset), .write_en(write_en), .data_in(data_in), .read_en(read_en),
    .data_out(d1), .limit(limit), .clear_errors(clear_errors), .is_full(full1),
    .is_empty(empty1), .count(cnt1), .overflow(ovf1), .underflow(udf1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue bounded by limit+1, updated from pre-edge inputs.
  always @(posedge clk) begin
    int  cap;
    bit  full, empty;
    if (reset) begin
      q.delete();
      m_dout = 8'h00;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      model_valid = 1'b1;
    end else begin
      cap   = int'(limit) + 1;
      full  = (q.size() >= cap);
      empty = (q.size() == 0);
      if (write_en && full)  m_ovf = 1'b1;
      else if (clear_errors) m_ovf = 1'b0;
      if (read_en && empty)  m_udf = 1'b1;
      else if (clear_errors) m_udf = 1'b0;
      if (read_en && !empty) m_dout = q.pop_front();
      if (write_en && !full) q.push_back(data_in);
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("count_reg",  32'(cnt0), 32'(q.size()));
      check("count_fwft", 32'(cnt1), 32'(q.size()));
      check("full_reg",   32'(full0), 32'(q.size() >= int'(limit) + 1));
      check("full_fwft",  32'(full1), 32'(q.size() >= int'(limit) + 1));
      check("empty_reg",  32'(empty0), 32'(q.size() == 0));
      check("empty_fwft", 32'(empty1), 32'(q.size() == 0));
      check("ovf_reg",    32'(ovf0), 32'(m_ovf));
      check("ovf_fwft",   32'(ovf1), 32'(m_ovf));
      check("udf_reg",    32'(udf0), 32'(m_udf));
      check("udf_fwft",   32'(udf1), 32'(m_udf));
      check("dout_reg",   32'(d0), 32'(m_dout));
      if (q.size() != 0) check("dout_fwft", 32'(d1), 32'(q[0]));
    end
  end

  task automatic step(input bit we, input logic [7:0] din, input bit re,
                      input logic [1:0] lim, input bit clr, input bit rst);
    write_en     = we;
    data_in      = din;
    read_en      = re;
    limit        = lim;
    clear_errors = clr;
    reset        = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; write_en = 1'b0; read_en = 1'b0; clear_errors = 1'b0;
    data_in = 8'h00; limit = 2'd1;
    step(0, 8'h00, 0, 2'd1, 0, 1);
    check("rst_count", 32'(cnt0), 32'd0);
    check("rst_empty", 32'(empty0), 32'd1);
    check("rst_full",  32'(full0), 32'd0);
    check("rst_dout",  32'(d0), 32'h00);
    check("rst_flags", 32'({ovf0, udf0}), 32'd0);

    // Fill/drain at limit=1
    step(1, 8'h55, 0, 2'd1, 0, 0); check("t1_cnt1", 32'(cnt0), 32'd1);
    step(1, 8'h66, 0, 2'd1, 0, 0); check("t1_cnt2", 32'(cnt0), 32'd2);
    check("t1_full", 32'(full0), 32'd1);
    step(0, 8'h00, 1, 2'd1, 0, 0); check("t1_rd55", 32'(d0), 32'h55);
    step(0, 8'h00, 1, 2'd1, 0, 0); check("t1_rd66", 32'(d0), 32'h66);
    check("t1_empty", 32'(empty0), 32'd1);
    check("t1_cnt0", 32'(cnt0), 32'd0);

    // Overflow and wrap at limit=3
    step(1, 8'h11, 0, 2'd3, 0, 0);
    step(1, 8'h22, 0, 2'd3, 0, 0);
    step(1, 8'h77, 0, 2'd3, 0, 0);
    step(1, 8'h88, 0, 2'd3, 0, 0); check("t2_full", 32'(full0), 32'd1);
    step(1, 8'h33, 0, 2'd3, 0, 0); check("t2_ovf", 32'(ovf0), 32'd1);
    check("t2_cnt4", 32'(cnt0), 32'd4);
    step(0, 8'h00, 1, 2'd3, 0, 0); check("t2_rd11", 32'(d0), 32'h11);
    step(0, 8'h00, 1, 2'd3, 0, 0); check("t2_rd22", 32'(d0), 32'h22);
    step(0, 8'h00, 1, 2'd3, 0, 0); check("t2_rd77", 32'(d0), 32'h77);
    step(0, 8'h00, 1, 2'd3, 0, 0); check("t2_rd88", 32'(d0), 32'h88);
    step(0, 8'h00, 0, 2'd3, 1, 0); check("t2_clr", 32'({ovf0, udf0}), 32'd0);

    // Minimum capacity at limit=0
    step(1, 8'h99, 0, 2'd0, 0, 0); check("t3_full", 32'(full0), 32'd1);
    step(1, 8'h44, 0, 2'd0, 0, 0); check("t3_ovf", 32'(ovf0), 32'd1);
    step(0, 8'h00, 1, 2'd0, 0, 0); check("t3_rd99", 32'(d0), 32'h99);
    step(0, 8'h00, 1, 2'd0, 0, 0); check("t3_udf", 32'(udf0), 32'd1);
    check("t3_hold", 32'(d0), 32'h99);
    step(0, 8'h00, 0, 2'd0, 1, 0);

    // Simultaneous read+write at full and at empty
    step(1, 8'hA1, 0, 2'd1, 0, 0);
    step(1, 8'hB2, 0, 2'd1, 0, 0);
    step(1, 8'hC3, 1, 2'd1, 0, 0); check("t4_cnt1", 32'(cnt0), 32'd1);
    check("t4_ovf", 32'(ovf0), 32'd1);
    check("t4_rdA1", 32'(d0), 32'hA1);
    step(0, 8'h00, 1, 2'd1, 1, 0); check("t4_rdB2", 32'(d0), 32'hB2);
    step(1, 8'hD4, 1, 2'd1, 0, 0); check("t4_e_cnt", 32'(cnt0), 32'd1);
    check("t4_udf", 32'(udf0), 32'd1);
    check("t4_hold", 32'(d0), 32'hB2);
    step(0, 8'h00, 1, 2'd1, 1, 0); check("t4_rdD4", 32'(d0), 32'hD4);

    // Limit lowered below occupancy
    step(1, 8'hE1, 0, 2'd3, 0, 0);
    step(1, 8'hE2, 0, 2'd3, 0, 0);
    step(1, 8'hE3, 0, 2'd3, 0, 0);
    step(0, 8'h00, 0, 2'd1, 0, 0); check("t5_full", 32'(full0), 32'd1);
    step(1, 8'hFF, 0, 2'd1, 0, 0); check("t5_ovf", 32'(ovf0), 32'd1);
    check("t5_cnt3", 32'(cnt0), 32'd3);
    step(0, 8'h00, 1, 2'd1, 0, 0); check("t5_rdE1", 32'(d0), 32'hE1);
    check("t5_full2", 32'(full0), 32'd1);
    step(0, 8'h00, 1, 2'd1, 0, 0); check("t5_rdE2", 32'(d0), 32'hE2);
    check("t5_nfull", 32'(full0), 32'd0);
    step(0, 8'h00, 1, 2'd1, 1, 0); check("t5_rdE3", 32'(d0), 32'hE3);
    check("t5_clr", 32'({ovf0, udf0}), 32'd0);

    // FWFT head visibility and reset mid-stream
    step(1, 8'hA5, 0, 2'd1, 0, 0); check("t6_fwA5", 32'(d1), 32'hA5);
    step(1, 8'h5A, 0, 2'd1, 0, 0); check("t6_fwA5b", 32'(d1), 32'hA5);
    step(1, 8'h77, 0, 2'd1, 0, 0); check("t6_ovf", 32'(ovf1), 32'd1);
    step(0, 8'h00, 1, 2'd1, 0, 0); check("t6_fw5A", 32'(d1), 32'h5A);
    step(1, 8'h12, 1, 2'd1, 0, 1); check("t6_rcnt", 32'(cnt1), 32'd0);
    check("t6_rempty", 32'(empty1), 32'd1);
    check("t6_rflags", 32'({ovf1, udf1, ovf0, udf0}), 32'd0);
    check("t6_rdout", 32'(d0), 32'h00);

    // Randomized traffic checked every cycle against the model
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 199) == 0));
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/limit_fifo.md
Name: limit_fifo

Overview:
- Single-clock, parametrised byte/word FIFO with a run-time programmable capacity (`limit`), occupancy count and sticky error flags.
- Next generation of the team's limit-controlled FIFO: generalised in width and depth, with an optional first-word-fall-through (FWFT) read mode.
- Sits between the teletext packet/byte producers and the display-side consumers, in the same clock domain.

Parameters:
- DATA_W, 8: data word width in bits.
- ADDR_W, 2: address width; physical depth DEPTH = 2**ADDR_W.
- FWFT, 0: 0 = registered read (1-cycle latency after `read_en`); 1 = head word visible on `data_out` while not empty.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- write_en  in  1  write request, sampled at the edge.
- data_in  in  DATA_W  write data.
- read_en  in  1  read (pop) request.
- data_out  out  DATA_W  read data.
- limit  in  ADDR_W  programmable capacity; effective capacity cap = limit+1 (range 1..DEPTH).
- clear_errors  in  1  clears `overflow` and `underflow`.
- is_full  out  1  count >= cap.
- is_empty  out  1  count == 0.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky flag: a write was rejected.
- underflow  out  1  sticky flag: a read was rejected.

Behaviour:
- Reset values (reset=1 at an edge): wr_ptr=0, rd_ptr=0, count=0, is_empty=1, is_full=0, data_out=0, overflow=0, underflow=0.
  - Storage array is not reset.
  - Reset overrides every other input in that cycle, including mid-burst; queued data is discarded.
- Acceptance, evaluated on pre-edge state:
  - wr_ok = write_en & !is_full.
  - rd_ok = read_en & !is_empty.
- Write (wr_ok): mem[wr_ptr] <= data_in; wr_ptr increments modulo DEPTH (natural wrap at ADDR_W bits).
- Read (rd_ok): rd_ptr increments modulo DEPTH.
  - FWFT=0: data_out <= mem[rd_ptr] at the same edge; data is valid from that edge (1-cycle latency). data_out holds its value when no read is accepted.
  - FWFT=1: data_out = mem[rd_ptr] whenever !is_empty. It is don't-care when empty; the bench checks it only when !is_empty. rd_ok advances to the next word.
- Count: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither.
- Simultaneous read and write:
  - When full (count==cap), the write is rejected even if the read is accepted; count becomes cap-1.
  - When empty, the read is rejected (underflow set) and the write is accepted; count becomes 1.
  - A read never returns data written in the same cycle.
- is_full and is_empty are combinational from registered count and the live `limit`:
  - is_full = (count >= limit+1); is_empty = (count == 0).
  - `limit` may change at any cycle and takes effect immediately.
  - Lowering `limit` below count drops no data: is_full stays asserted and writes are rejected until reads bring count below cap.
  - Raising `limit` deasserts is_full in the same cycle.
- limit+1 is computed at ADDR_W+1 bits, so limit = 2**ADDR_W-1 gives cap = DEPTH with no truncation.
- Error flags:
  - overflow <= 1 on (write_en & is_full); underflow <= 1 on (read_en & is_empty).
  - Both clear on clear_errors.
  - A set in the same cycle as clear_errors wins; the flag reads 1.
- Pointers are never compared directly; full/empty derive solely from count, so wrap-around is unambiguous.

Decomposition:
- Package fifo_pkg holds:
  - default DATA_W / ADDR_W constants;
  - a function computing cap from limit at ADDR_W+1 bits.
- One sub-module, fifo_ram: simple dual-port register array (DEPTH x DATA_W).
  - Synchronous write port.
  - Asynchronous read port: limit_fifo registers the output for FWFT=0 and uses it directly for FWFT=1.
- Pointer, count, flag and output logic stay in limit_fifo.

Test Plan:
- Basic fill/drain at limit=1 (DATA_W=8, ADDR_W=2, FWFT=0): write 55, then 66.
  - Required: count 1 then 2; is_full=1 after the second write.
  - Two reads: data_out=55, then 66; is_empty=1, count=0.
- Overflow and wrap at limit=3: write 11, 22, 77, 88, then write 33.
  - Required: is_full after 88; 33 rejected; overflow=1; count=4.
  - Four reads return 11, 22, 77, 88; pointers have wrapped past 3 to 0.
- Minimum capacity at limit=0: write 99.
  - Required: is_full=1 immediately; a second write sets overflow.
  - Read returns 99. A further read on empty sets underflow=1 and data_out holds 99.
- Simultaneous events:
  - At full (limit=1, 2 entries), read+write in one cycle: read accepted, write rejected, count=1, overflow=1.
  - At empty, read+write: write accepted, count=1, underflow=1.
- Limit change mid-fill: with limit=3 and 3 entries, set limit=1.
  - Required: is_full=1, writes rejected, no data lost.
  - After 2 reads (count=1), is_full=0.
  - clear_errors pulse clears both flags.
- FWFT=1 and reset: write 0xA5, 0x5A.
  - Required: data_out=0xA5 the cycle after the first write, without read_en; one read shows 0x5A.
  - Assert reset mid-stream: next cycle count=0, is_empty=1, flags=0.
